// File: rtl/gate_trigger_dispatcher.sv
// Gate level-change detector: one trigger per gate per logic frame, queued in a
// show-ahead FIFO drained by the wire-propagation engine over valid/ready.
module gate_trigger_dispatcher #(
    parameter int unsigned GATE_COUNT = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ID_WIDTH   = (GATE_COUNT > 1) ? $clog2(GATE_COUNT) : 1
) (
    input  logic                  clk,
    input  logic                  logic_reset,
    input  logic                  frame_start,
    input  logic [GATE_COUNT-1:0] gate_out,
    output logic                  trig_valid,
    input  logic                  trig_ready,
    output logic [ID_WIDTH-1:0]   trig_id,
    output logic                  trig_level,
    output logic                  busy
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e                state_q, state_d;
    logic [GATE_COUNT-1:0] gate_q, gate_d;
    logic [GATE_COUNT-1:0] sent_q, sent_d;
    logic [GATE_COUNT-1:0] fired_q, fired_d;
    logic [ID_WIDTH:0]     mem_q [FIFO_DEPTH];
    logic [ID_WIDTH:0]     mem_d [FIFO_DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       cnt_q, cnt_d;

    logic [GATE_COUNT-1:0] pending;
    logic [ID_WIDTH-1:0]   win_id;
    logic [ID_WIDTH:0]     head;
    logic                  full;
    logic                  push;
    logic                  pop;

    // Pending is derived each cycle so a toggle that returns to the sent level cancels itself.
    always_comb begin
        pending = '0;
        if (state_q == StRun) begin
            pending = (gate_q ^ sent_q) & ~fired_q;
        end
    end

    always_comb begin
        win_id = '0;
        for (int i = GATE_COUNT - 1; i >= 0; i--) begin
            if (pending[i]) begin
                win_id = ID_WIDTH'(i);
            end
        end
    end

    assign full       = (cnt_q == CntW'(FIFO_DEPTH));
    assign trig_valid = (cnt_q != '0);
    assign pop        = trig_valid & trig_ready;
    assign push       = (|pending) & (~full | pop);
    assign head       = mem_q[rd_ptr_q];
    assign trig_id    = trig_valid ? head[ID_WIDTH:1] : '0;
    assign trig_level = trig_valid ? head[0] : 1'b0;
    assign busy       = (|pending) | trig_valid;

    always_comb begin
        state_d  = state_q;
        gate_d   = gate_q;
        sent_d   = sent_q;
        fired_d  = fired_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            StInit: begin
                gate_d  = gate_out;
                sent_d  = gate_out;
                state_d = StRun;
            end
            StRun: begin
                gate_d = gate_out;
                if (frame_start) begin
                    fired_d = '0;
                end
                // Push after the frame clear so the pushed gate stays fired.
                if (push) begin
                    sent_d[win_id]  = gate_q[win_id];
                    fired_d[win_id] = 1'b1;
                    mem_d[wr_ptr_q] = {win_id, gate_q[win_id]};
                    wr_ptr_d        = wr_ptr_q + 1'b1;
                end
            end
            default: state_d = StInit;
        endcase

        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge logic_reset) begin
        if (!logic_reset) begin
            state_q  <= StInit;
            gate_q   <= '0;
            sent_q   <= '0;
            fired_q  <= '0;
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            gate_q   <= gate_d;
            sent_q   <= sent_d;
            fired_q  <= fired_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_gate_trigger_dispatcher.sv
// Scoreboard bench for gate_trigger_dispatcher: a rule-level model queues expected
// events, a negedge monitor compares every accepted trigger and the status flags.
module tb_gate_trigger_dispatcher;

    localparam int G = 8;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         logic_reset = 1'b0;
    logic         frame_start = 1'b0;
    logic [G-1:0] gate_out = '0;
    logic         trig_valid;
    logic         trig_ready = 1'b1;
    logic [2:0]   trig_id;
    logic         trig_level;
    logic         busy;

    int passed = 0;
    int total  = 0;

    gate_trigger_dispatcher #(
        .GATE_COUNT(G),
        .FIFO_DEPTH(D)
    ) dut (
        .clk        (clk),
        .logic_reset(logic_reset),
        .frame_start(frame_start),
        .gate_out   (gate_out),
        .trig_valid (trig_valid),
        .trig_ready (trig_ready),
        .trig_id    (trig_id),
        .trig_level (trig_level),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference model: last seen level, last dispatched level, per-frame fired set.
    bit [G-1:0] m_gate, m_sent, m_fired;
    bit         m_init;
    int         m_count;
    bit [3:0]   exp_q[$];

    always @(posedge clk or negedge logic_reset) begin
        if (!logic_reset) begin
            m_init  = 1'b1;
            m_gate  = '0;
            m_sent  = '0;
            m_fired = '0;
            m_count = 0;
            exp_q.delete();
        end else if (m_init) begin
            m_gate = gate_out;
            m_sent = gate_out;
            m_init = 1'b0;
        end else begin
            int win;
            bit do_push, do_pop;
            win = -1;
            for (int i = 0; i < G; i++)
                if (win < 0 && m_gate[i] != m_sent[i] && !m_fired[i]) win = i;
            do_pop  = (m_count > 0) && trig_ready;
            do_push = (win >= 0) && ((m_count < D) || do_pop);
            if (frame_start) m_fired = '0;
            if (do_push) begin
                exp_q.push_back({3'(win), m_gate[win]});
                m_sent[win]  = m_gate[win];
                m_fired[win] = 1'b1;
            end
            m_count = m_count + int'(do_push) - int'(do_pop);
            m_gate  = gate_out;
        end
    end

    int       obs_q[$];
    int       obs_cnt[G];
    bit [G-1:0] obs_lvl;

    always @(negedge clk) begin
        bit mbusy;
        bit [3:0] e;
        mbusy = (m_count > 0);
        if (!m_init)
            for (int i = 0; i < G; i++)
                if (m_gate[i] != m_sent[i] && !m_fired[i]) mbusy = 1'b1;
        check_eq("trig_valid", int'(trig_valid), int'(m_count > 0));
        check_eq("busy", int'(busy), int'(mbusy));
        if (trig_valid && trig_ready) begin
            check_eq("scoreboard_has_entry", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_eq("trig_id", int'(trig_id), int'(e[3:1]));
                check_eq("trig_level", int'(trig_level), int'(e[0]));
            end
            obs_q.push_back(int'(trig_id));
            obs_cnt[trig_id]++;
            obs_lvl[trig_id] = trig_level;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input logic [G-1:0] val);
        logic_reset = 1'b0;
        gate_out    = val;
        frame_start = 1'b0;
        trig_ready  = 1'b1;
        cyc(2);
        obs_q.delete();
        for (int i = 0; i < G; i++) obs_cnt[i] = 0;
        logic_reset = 1'b1;
    endtask

    initial begin
        // Reset with non-zero levels: nothing must ever be dispatched.
        do_reset(8'hA5);
        check_eq("reset_trig_id", int'(trig_id), 0);
        check_eq("reset_trig_level", int'(trig_level), 0);
        check_eq("reset_busy", int'(busy), 0);
        cyc(10);
        check_eq("a5_no_events", obs_q.size(), 0);
        check_eq("a5_busy", int'(busy), 0);

        // Single rise on bit 3: two-cycle latency, one event.
        do_reset(8'h00);
        cyc(1);
        gate_out = 8'h08;
        @(posedge clk);
        @(negedge clk);
        check_eq("lat_not_yet_valid", int'(trig_valid), 0);
        @(posedge clk);
        #1;
        check_eq("lat_valid", int'(trig_valid), 1);
        check_eq("lat_id", int'(trig_id), 3);
        check_eq("lat_level", int'(trig_level), 1);
        cyc(4);
        check_eq("bit3_count", obs_cnt[3], 1);
        check_eq("bit3_total", obs_q.size(), 1);

        // Two simultaneous rises: lowest index first.
        do_reset(8'h00);
        cyc(1);
        gate_out = 8'h81;
        cyc(6);
        check_eq("pair_count", obs_q.size(), 2);
        if (obs_q.size() == 2) begin
            check_eq("pair_first", obs_q[0], 0);
            check_eq("pair_second", obs_q[1], 7);
        end

        // Deferred edge after fire; released by frame_start.
        do_reset(8'h00);
        cyc(1);
        gate_out = 8'h04;
        cyc(4);
        gate_out = 8'h00;
        cyc(4);
        check_eq("defer_held", obs_cnt[2], 1);
        frame_start = 1'b1;
        cyc(1);
        frame_start = 1'b0;
        cyc(3);
        check_eq("defer_released", obs_cnt[2], 2);
        check_eq("defer_level", int'(obs_lvl[2]), 0);

        // Bit 5 glitches while bit 4 wins arbitration: cancelled.
        do_reset(8'h00);
        cyc(1);
        gate_out = 8'h30;
        cyc(1);
        gate_out = 8'h10;
        cyc(5);
        check_eq("glitch_bit4", obs_cnt[4], 1);
        check_eq("glitch_bit5", obs_cnt[5], 0);

        // Backpressure: FIFO fills, extra gates stay pending, full drain in order.
        do_reset(8'h00);
        cyc(1);
        trig_ready = 1'b0;
        gate_out   = 8'h3F;
        cyc(8);
        check_eq("bp_valid", int'(trig_valid), 1);
        check_eq("bp_busy", int'(busy), 1);
        check_eq("bp_none_accepted", obs_q.size(), 0);
        trig_ready = 1'b1;
        cyc(10);
        check_eq("bp_drained", obs_q.size(), 6);
        for (int i = 0; i < obs_q.size(); i++) check_eq("bp_order", obs_q[i], i);

        // Asynchronous reset in the middle of a drain.
        do_reset(8'h00);
        cyc(1);
        trig_ready = 1'b0;
        gate_out   = 8'h3F;
        cyc(8);
        trig_ready = 1'b1;
        cyc(2);
        #3;
        logic_reset = 1'b0;
        #1;
        check_eq("async_rst_valid", int'(trig_valid), 0);
        check_eq("async_rst_busy", int'(busy), 0);
        check_eq("async_rst_id", int'(trig_id), 0);
        for (int i = 0; i < obs_q.size(); i++) check_eq("rst_prefix_order", obs_q[i], i);
        cyc(2);

        // Randomized traffic against the model.
        do_reset(8'($urandom_range(0, 255)));
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 2) == 0) gate_out[$urandom_range(0, G - 1)] ^= 1'b1;
            trig_ready  = ($urandom_range(0, 3) != 0);
            frame_start = ($urandom_range(0, 7) == 0);
            cyc(1);
        end

        // Settle: hold levels, open frames until everything is dispatched.
        frame_start = 1'b0;
        trig_ready  = 1'b1;
        repeat (4) begin
            frame_start = 1'b1;
            cyc(1);
            frame_start = 1'b0;
            cyc(14);
        end
        check_eq("final_scoreboard_empty", exp_q.size(), 0);
        check_eq("final_busy", int'(busy), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
